// File: rtl/i2c_xfer_arbiter.sv
// Round-robin arbiter that walks one shared i2c_master through a complete multi-byte write per grant.
// Grant appears 2 cycles after a request. Payload is pulled one byte per LOAD. Per-state timeout is built only with I2C_ARB_TIMEOUT_EN.
module i2c_xfer_arbiter #(
  parameter int REQ_NUM     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 16,
  parameter int LEN_WIDTH   = 4,
  parameter int TMO_WIDTH   = 16
) (
  input  logic                                 clk_i,
  input  logic                                 a_rst_n_i,
  input  logic [REQ_NUM-1:0]                   req_i,
  input  logic [REQ_NUM*(DATA_WIDTH-1)-1:0]    addr_i,
  input  logic [REQ_NUM*LEN_WIDTH-1:0]         len_i,
  input  logic [PRESC_WIDTH-1:0]               prescale_i,
  input  logic [TMO_WIDTH-1:0]                 timeout_i,
  output logic [REQ_NUM-1:0]                   gnt_o,
  input  logic [DATA_WIDTH-1:0]                wr_data_i,
  input  logic                                 wr_valid_i,
  output logic                                 wr_ready_o,
  output logic                                 done_o,
  output logic                                 err_o,
  output logic                                 m_en_o,
  output logic [DATA_WIDTH-2:0]                m_slave_addr_o,
  output logic                                 m_dir_o,
  output logic [DATA_WIDTH-1:0]                m_data_o,
  output logic                                 m_write_o,
  output logic                                 m_stop_o,
  output logic [PRESC_WIDTH-1:0]               m_prescale_o,
  input  logic                                 m_byte_done_i,
  input  logic                                 m_nack_i,
  input  logic                                 m_busy_i
);

  localparam int IW = $clog2(REQ_NUM);
  localparam int AW = DATA_WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_LOAD, S_START, S_XFER, S_STOP, S_RELEASE
  } state_t;

  state_t                 state_q;
  logic [IW-1:0]          last_q;
  logic [IW-1:0]          idx_q;
  logic [AW-1:0]          addr_q;
  logic [LEN_WIDTH-1:0]   remain_q;
  logic                   first_q;
  logic                   err_q;
  logic [REQ_NUM-1:0]     gnt_q;
  logic                   wr_ready_q;
  logic                   done_q;
  logic                   err_o_q;
  logic                   m_en_q;
  logic [AW-1:0]          m_addr_q;
  logic                   m_dir_q;
  logic [DATA_WIDTH-1:0]  m_data_q;
  logic                   m_write_q;
  logic                   m_stop_q;

  logic                   win_vld;
  logic [IW-1:0]          win_idx;
  logic [IW-1:0]          cand;
  logic [AW-1:0]          win_addr;
  logic [LEN_WIDTH-1:0]   win_len;
  logic                   tmo_hit;

  // Scan downward so the candidate closest after last_q is the final one written.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = REQ_NUM; i >= 1; i--) begin
      cand = IW'((int'(last_q) + i) % REQ_NUM);
      if (req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign win_addr = addr_i[int'(win_idx)*AW +: AW];
  assign win_len  = len_i[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];

`ifdef I2C_ARB_TIMEOUT_EN
  state_t                 state_last_q;
  logic [TMO_WIDTH-1:0]   tmo_q;
  logic [TMO_WIDTH-1:0]   elapsed;

  // elapsed is the number of whole cycles already spent in the current state.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_last_q <= S_IDLE;
      tmo_q        <= '0;
    end else begin
      state_last_q <= state_q;
      if (state_q != state_last_q) tmo_q <= TMO_WIDTH'(1);
      else if (tmo_q != '1)        tmo_q <= tmo_q + TMO_WIDTH'(1);
    end
  end

  assign elapsed = (state_q != state_last_q) ? '0 : tmo_q;
  assign tmo_hit = (timeout_i != '0) &&
                   (({1'b0, elapsed} + (TMO_WIDTH+1)'(1)) == {1'b0, timeout_i});
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_q    <= S_IDLE;
      last_q     <= IW'(REQ_NUM - 1);
      idx_q      <= '0;
      addr_q     <= '0;
      remain_q   <= '0;
      first_q    <= 1'b0;
      err_q      <= 1'b0;
      gnt_q      <= '0;
      wr_ready_q <= 1'b0;
      done_q     <= 1'b0;
      err_o_q    <= 1'b0;
      m_en_q     <= 1'b0;
      m_addr_q   <= '0;
      m_dir_q    <= 1'b0;
      m_data_q   <= '0;
      m_write_q  <= 1'b0;
      m_stop_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_o_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|req_i) state_q <= S_ARB;
        end
        S_ARB: begin
          if (win_vld) begin
            idx_q      <= win_idx;
            addr_q     <= win_addr;
            remain_q   <= win_len;
            first_q    <= 1'b1;
            err_q      <= 1'b0;
            gnt_q      <= REQ_NUM'(1) << win_idx;
            wr_ready_q <= 1'b1;
            state_q    <= S_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (tmo_hit) begin
            wr_ready_q <= 1'b0;
            err_q      <= 1'b1;
            m_stop_q   <= 1'b1;
            state_q    <= S_STOP;
          end else if (wr_valid_i && wr_ready_q) begin
            m_data_q   <= wr_data_i;
            wr_ready_q <= 1'b0;
            first_q    <= 1'b0;
            if (first_q) begin
              m_en_q   <= 1'b1;
              m_addr_q <= addr_q;
              m_dir_q  <= 1'b0;
              state_q  <= S_START;
            end else begin
              m_write_q <= 1'b1;
              state_q   <= S_XFER;
            end
          end
        end
        S_START: begin
          if (tmo_hit) begin
            err_q    <= 1'b1;
            m_stop_q <= 1'b1;
            state_q  <= S_STOP;
          end else begin
            m_write_q <= 1'b1;
            state_q   <= S_XFER;
          end
        end
        S_XFER: begin
          // NACK outranks a coincident byte-done so the error is never lost.
          if (tmo_hit || m_nack_i) begin
            err_q     <= 1'b1;
            m_write_q <= 1'b0;
            m_stop_q  <= 1'b1;
            state_q   <= S_STOP;
          end else if (m_byte_done_i) begin
            m_write_q <= 1'b0;
            if (remain_q == '0) begin
              m_stop_q <= 1'b1;
              state_q  <= S_STOP;
            end else begin
              remain_q   <= remain_q - LEN_WIDTH'(1);
              wr_ready_q <= 1'b1;
              state_q    <= S_LOAD;
            end
          end
        end
        S_STOP: begin
          if (!m_busy_i || tmo_hit) begin
            m_stop_q <= 1'b0;
            m_en_q   <= 1'b0;
            gnt_q    <= '0;
            done_q   <= 1'b1;
            err_o_q  <= err_q | (tmo_hit & m_busy_i);
            state_q  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          last_q  <= idx_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o          = gnt_q;
  assign wr_ready_o     = wr_ready_q;
  assign done_o         = done_q;
  assign err_o          = err_o_q;
  assign m_en_o         = m_en_q;
  assign m_slave_addr_o = m_addr_q;
  assign m_dir_o        = m_dir_q;
  assign m_data_o       = m_data_q;
  assign m_write_o      = m_write_q;
  assign m_stop_o       = m_stop_q;
  assign m_prescale_o   = prescale_i;

endmodule

// File: tb/tb_i2c_xfer_arbiter.sv
// Randomized scoreboard bench for i2c_xfer_arbiter with a requester driver and an i2c_master responder model.
module tb_i2c_xfer_arbiter;
  localparam int N = 4, DW = 8, AW = 7, PW = 16, LW = 4, TW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic [N-1:0] req;
  logic [N*AW-1:0] addr;
  logic [N*LW-1:0] len;
  logic [PW-1:0] prescale = 16'hA5C3;
  logic [TW-1:0] timeout = '0;
  logic [N-1:0] gnt;
  logic [DW-1:0] wr_data = '0;
  logic wr_valid = 1'b0, wr_ready, done, err;
  logic m_en, m_dir, m_write, m_stop;
  logic m_byte_done = 1'b0, m_nack = 1'b0, m_busy = 1'b0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [PW-1:0] m_prescale;

  i2c_xfer_arbiter #(.REQ_NUM(N), .DATA_WIDTH(DW), .PRESC_WIDTH(PW), .LEN_WIDTH(LW), .TMO_WIDTH(TW)) dut (
    .clk_i(clk), .a_rst_n_i(rst_n), .req_i(req), .addr_i(addr), .len_i(len),
    .prescale_i(prescale), .timeout_i(timeout), .gnt_o(gnt),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .done_o(done), .err_o(err), .m_en_o(m_en), .m_slave_addr_o(m_addr), .m_dir_o(m_dir),
    .m_data_o(m_data), .m_write_o(m_write), .m_stop_o(m_stop), .m_prescale_o(m_prescale),
    .m_byte_done_i(m_byte_done), .m_nack_i(m_nack), .m_busy_i(m_busy)
  );

  int total = 0, bad = 0;
  logic [AW-1:0] a_tab[N];
  logic [LW-1:0] l_tab[N];
  logic [DW-1:0] pay[N][16];
  int nack_at[N];
  bit nack_both[N];
  int want[N];
  int issued[N];
  int retired[N];
  bit stall = 1'b0, hold_ack = 1'b0;
  int cur = 0;
  int model_last = N - 1;

  int q_gnt[$];
  logic [DW-1:0] q_dat[$];
  logic [AW-1:0] q_adr[$];
  int q_nb[$];
  bit q_err[$];

  always_comb begin
    req = '0;
    addr = '0;
    len = '0;
    for (int k = 0; k < N; k++) begin
      req[k] = issued[k] > retired[k];
      addr[k*AW +: AW] = a_tab[k];
      len[k*LW +: LW] = l_tab[k];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] g);
    int r = -1;
    for (int i = 0; i < N; i++) if (g[i] && r < 0) r = i;
    return r;
  endfunction

  // Reference model: whole-transaction view of arbitration order, bytes delivered and error outcome.
  task automatic launch();
    int left[N];
    int rem = 0;
    int c, nb;
    bit e;
    for (int k = 0; k < N; k++) begin left[k] = want[k]; rem += want[k]; end
    while (rem > 0) begin
      c = -1;
      for (int i = 1; i <= N; i++)
        if (c < 0 && left[(model_last + i) % N] > 0) c = (model_last + i) % N;
      e  = stall || (nack_at[c] >= 0 && nack_at[c] <= int'(l_tab[c]));
      nb = stall ? 0 : (e ? nack_at[c] + 1 : int'(l_tab[c]) + 1);
      q_gnt.push_back(c);
      for (int j = 0; j < nb; j++) begin q_dat.push_back(pay[c][j]); q_adr.push_back(a_tab[c]); end
      q_nb.push_back(nb);
      q_err.push_back(e);
      left[c]--; rem--; model_last = c;
    end
    for (int k = 0; k < N; k++) issued[k] += want[k];
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_gnt"}, gnt, 0);          chk({nm, "_wr_ready"}, wr_ready, 0);
    chk({nm, "_done"}, done, 0);        chk({nm, "_err"}, err, 0);
    chk({nm, "_m_en"}, m_en, 0);        chk({nm, "_m_write"}, m_write, 0);
    chk({nm, "_m_stop"}, m_stop, 0);    chk({nm, "_m_dir"}, m_dir, 0);
    chk({nm, "_m_addr"}, m_addr, 0);    chk({nm, "_m_data"}, m_data, 0);
    chk({nm, "_prescale"}, m_prescale, prescale);
  endtask

  task automatic reset_flush(input string nm);
    rst_n = 1'b0;
    #1;
    check_reset(nm);
    q_gnt.delete(); q_dat.delete(); q_adr.delete(); q_nb.delete(); q_err.delete();
    for (int k = 0; k < N; k++) issued[k] = retired[k];
    model_last = N - 1;
    hold_ack = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((q_err.size() != 0 || q_gnt.size() != 0) && n < 4000) begin @(negedge clk); n++; end
    chk({nm, "_drained"}, q_err.size(), 0);
    chk({nm, "_bytes_left"}, q_dat.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_want();
    for (int k = 0; k < N; k++) begin want[k] = 0; nack_at[k] = -1; nack_both[k] = 1'b0; end
  endtask

  // Requester side: supplies the granted requester's payload in order, with random valid gaps.
  bit rdy_prev = 1'b0;
  int bidx = 0;
  logic [N-1:0] gprev_d = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_valid = 1'b0; bidx = 0; rdy_prev = 1'b0; gprev_d = '0;
    end else begin
      if (wr_valid && rdy_prev) bidx++;
      if (gnt != 0 && gprev_d == 0) begin cur = idx_of(gnt); bidx = 0; end
      if (done) retired[cur]++;
      wr_valid = (gnt != 0) && wr_ready && !stall && bidx < 16 && ($urandom_range(0, 2) != 0);
      wr_data  = (bidx < 16) ? pay[cur][bidx] : '0;
      rdy_prev = wr_ready;
      gprev_d  = gnt;
    end
  end

  // i2c_master responder: random ack latency, planned NACKs, busy drops two cycles into STOP.
  bit armed = 1'b0, responded = 1'b0;
  int wdly = 0, mcnt = 0, stop_cnt = 0;
  always @(negedge clk) begin
    m_byte_done = 1'b0;
    m_nack = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0; armed = 1'b0; responded = 1'b0; mcnt = 0; stop_cnt = 0;
    end else begin
      stop_cnt = m_stop ? stop_cnt + 1 : 0;
      m_busy = m_en && stop_cnt < 2;
      if (!m_en) mcnt = 0;
      if (!m_write) begin
        armed = 1'b0; responded = 1'b0;
      end else if (!responded && !hold_ack) begin
        if (!armed) begin armed = 1'b1; wdly = $urandom_range(0, 3); end
        if (wdly == 0) begin
          responded = 1'b1;
          if (nack_at[cur] == mcnt) begin m_nack = 1'b1; m_byte_done = nack_both[cur]; end
          else m_byte_done = 1'b1;
          mcnt++;
        end else begin
          wdly--;
        end
      end
    end
  end

  // Monitor: pops expectations as grants, bytes and completions appear.
  logic [N-1:0] gprev_m = '0;
  logic wprev = 1'b0;
  int nseen = 0;
  bit stop_seen = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      gprev_m = '0; wprev = 1'b0; nseen = 0; stop_seen = 1'b0;
    end else begin
      if (gnt != 0 && gprev_m == 0) begin
        chk("gnt_onehot", $onehot(gnt), 1);
        if (q_gnt.size() > 0) chk("gnt_idx", idx_of(gnt), q_gnt.pop_front());
        else chk("gnt_unexpected", q_gnt.size(), 1);
      end
      if (m_write && !wprev) begin
        nseen++;
        chk("dir_write", m_dir, 0);
        chk("en_in_xfer", m_en, 1);
        if (q_dat.size() > 0) begin
          chk("wr_byte", m_data, q_dat.pop_front());
          chk("slave_addr", m_addr, q_adr.pop_front());
        end else chk("byte_unexpected", q_dat.size(), 1);
      end
      if (m_stop) stop_seen = 1'b1;
      if (done) begin
        if (q_err.size() > 0) begin
          chk("err_flag", err, q_err.pop_front());
          chk("nbytes", nseen, q_nb.pop_front());
        end else chk("done_unexpected", q_err.size(), 1);
        chk("stop_before_done", stop_seen, 1);
        chk("gnt_released", gnt, 0);
        nseen = 0;
        stop_seen = 1'b0;
      end else if (err) begin
        chk("err_without_done", err, 0);
      end
      gprev_m = gnt;
      wprev = m_write;
    end
  end

  initial begin
    int n, k;
    bit saw;
    for (int i = 0; i < N; i++) begin
      a_tab[i] = AW'(7'h10 + i); l_tab[i] = '0; issued[i] = 0; retired[i] = 0;
      for (int j = 0; j < 16; j++) pay[i][j] = DW'($urandom_range(0, 255));
    end
    clear_want();
    #2 rst_n = 1'b0;
    #1 check_reset("rst0");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Round robin, req=1011 held, one byte each: order 0,1,3,0,1,3.
    clear_want();
    want[0] = 2; want[1] = 2; want[3] = 2;
    launch();
    wait_drain("rr");

    // Single write of A1,B2,C3 to 0x50.
    clear_want();
    a_tab[0] = 7'h50; l_tab[0] = 4'd2;
    pay[0][0] = 8'hA1; pay[0][1] = 8'hB2; pay[0][2] = 8'hC3;
    want[0] = 1;
    launch();
    wait_drain("single");

    // NACK on the second byte of a four-byte transfer.
    clear_want();
    l_tab[2] = 4'd3; nack_at[2] = 1; want[2] = 1;
    launch();
    wait_drain("nack");

    // NACK and byte-done together on the last byte.
    clear_want();
    l_tab[1] = 4'd1; nack_at[1] = 1; nack_both[1] = 1'b1; want[1] = 1;
    launch();
    wait_drain("nack_both");

    for (int r = 0; r < 5; r++) begin
      clear_want();
      for (int i = 0; i < N; i++) begin
        want[i] = $urandom_range(0, 2);
        l_tab[i] = LW'($urandom_range(0, 4));
        a_tab[i] = AW'($urandom_range(0, 127));
        for (int j = 0; j < 16; j++) pay[i][j] = DW'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) nack_at[i] = $urandom_range(0, int'(l_tab[i]));
        nack_both[i] = 1'($urandom_range(0, 1));
      end
      launch();
      wait_drain("random");
    end

    // Requester never supplies data.
    clear_want();
    stall = 1'b1; l_tab[3] = '0; want[3] = 1;
`ifdef I2C_ARB_TIMEOUT_EN
    timeout = 16'd100;
    launch();
    n = 0;
    while (gnt == 0 && n < 100) begin @(negedge clk); n++; end
    chk("tmo_gnt", gnt, 4'b1000);
    k = 0;
    while (!m_stop && k < 300) begin @(negedge clk); k++; end
    chk("tmo_cycles_to_stop", k, 100);
    wait_drain("timeout");
    timeout = '0;
    stall = 1'b0;
`else
    timeout = 16'd100;
    launch();
    n = 0;
    while (gnt == 0 && n < 100) begin @(negedge clk); n++; end
    chk("stall_gnt", gnt, 4'b1000);
    saw = 1'b0;
    repeat (1000) begin @(negedge clk); if (err || done || m_stop) saw = 1'b1; end
    chk("stall_no_err", saw, 0);
    chk("stall_in_load", wr_ready, 1);
    timeout = '0;
    reset_flush("rst_stall");
`endif

    // Reset while the master holds the first byte in XFER.
    clear_want();
    hold_ack = 1'b1; l_tab[2] = 4'd2; want[2] = 1;
    launch();
    n = 0;
    while (!m_write && n < 100) begin @(negedge clk); n++; end
    chk("reached_xfer", m_write, 1);
    reset_flush("rst_xfer");

    // All four request after reset: requester 0 wins first.
    clear_want();
    for (int i = 0; i < N; i++) begin want[i] = 1; l_tab[i] = LW'($urandom_range(0, 2)); end
    launch();
    wait_drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
